dma_stream_exerciser: RTL and testbench
=======================================

# dma_stream_exerciser

Synthesizable AXI4-Stream traffic generator and checker for exercising the PS7 DMA path in hardware and in PS-level simulation. On `start` it emits a `len`-beat pattern stream on `m_axis` to the DMA MM2S/S2MM loop, checks the returned stream on `s_axis` against the same pattern, and reports error count, timeout and completion. Generalises the earlier fixed single-path soft-reset bring-up with configurable data width, multiple destination channels, two pattern modes and a progress watchdog.

## Interface
- `DATA_W`, 32, stream data width; legal 8..32.
- `NUM_CH`, 2, number of destination channels; `CH_W = max(1, $clog2(NUM_CH))`.
- `LEN_W`, 16, width of beat-count fields.
- `TIMEOUT`, 1024, cycles without an `s_axis` handshake before abort; ≥ 2.
- `clk`  in  1  single clock for all logic.
- `resetn`  in  1  reset, asynchronous assert, active-low.
- `start`  in  1  start request; sampled only in IDLE.
- `mode`  in  1  0 = incrementing, 1 = LFSR.
- `chan`  in  CH_W  channel, driven on `m_axis_tdest` and expected on `s_axis_tdest`.
- `len`  in  LEN_W  beats per transfer.
- `seed`  in  32  pattern seed.
- `m_axis_tdata/tvalid/tready/tlast/tdest`  out/out/in/out/out  DATA_W/1/1/1/CH_W  generated stream.
- `s_axis_tdata/tvalid/tready/tlast/tdest`  in/in/out/in/in  DATA_W/1/1/1/CH_W  returned stream.
- `busy`  out  1  transfer in progress.
- `done`  out  1  one-cycle completion pulse.
- `timeout`  out  1  sticky until next accepted start; last transfer aborted by watchdog.
- `err_count`  out  16  mismatches in last transfer, saturating at 0xFFFF.
- `rx_beats`  out  LEN_W  beats received in last transfer.

## Operation
- Start is accepted in IDLE when `start=1` and `len!=0`; `len=0` is ignored with no `busy` and no `done`. Start while busy is ignored.
- On accept, latch `mode`, `chan`, `len`, `seed`, and clear `err_count`, `rx_beats` and `timeout`.
- Pattern for beat i:
  - Incrementing: `(seed + i) mod 2^DATA_W`.
  - LFSR: 32-bit Galois, polynomial x^32+x^22+x^2+x+1, state seeded with `seed` (0 replaced by 1), advanced once per beat, data = `state[DATA_W-1:0]`.
- TX FSM:
  - IDLE → SEND on accept.
  - SEND: `tvalid=1`; advance on handshake; `tlast=1` on beat `len-1`. SEND → TXDONE after the last handshake.
  - TXDONE → IDLE when the RX FSM finishes.
- RX FSM:
  - IDLE → RECV on accept. In RECV, `s_axis_tready=1`.
  - Each handshake increments `rx_beats`; errors per beat are data ≠ expected, `tdest` ≠ latched `chan`, or `tlast` ≠ (beat == `len-1`). Each erroneous beat adds 1 to `err_count`.
  - RECV → FIN on the last expected beat, or on early `tlast`.
  - FIN pulses `done` and clears `busy`.
- Watchdog counts cycles in SEND/TXDONE/RECV without an `s_axis` handshake. On reaching `TIMEOUT`: set `timeout`, add 1 to `err_count`, force both FSMs to FIN/IDLE, drop `tvalid` and `tready`.
- Extra beats arriving after finish are not accepted (`tready=0`).

## Timing
- Reset (async, any state) drives: all outputs 0, FSMs to IDLE, watchdog cleared. A transfer in flight is abandoned with no `done`.
- Start accepted at edge N: `busy=1` and `m_axis_tvalid=1` after edge N; first data valid in the same cycle.
- `m_axis` data, `tlast` and `tdest` are registered and held stable while `tvalid && !tready`. `tvalid` never drops before its handshake except on watchdog abort.
- `done` is asserted the cycle after the final RX handshake or the timeout edge; `busy` falls in the same cycle.
- `err_count` and `rx_beats` are final by the `done` cycle.
- A new start is accepted in the cycle after `done`, giving a 1-cycle minimum gap.
- Watchdog counter width is `$clog2(TIMEOUT+1)`; it clears on every `s_axis` handshake.

## Structure
- Package `dma_exer_pkg`: TX/RX state enums, `MODE_INC`/`MODE_LFSR`, `LFSR_POLY = 32'h8020_0003`, error-count saturation constant.
- Sub-module `dma_exer_pattern` (seed load, step, mode → data), instantiated twice: TX generator and RX expected-value model.

## Test plan
- Loopback, `mode=0`, `seed=0x10`, `len=4`, `tready` always 1 → data 0x10..0x13, `tlast` on beat 3, `done` after 4 RX beats, `err_count=0`, `rx_beats=4`.
- LFSR, `seed=0`, `len=8`, random backpressure on both sides → sequence matches a model seeded with 1, held data stable under stall, `err_count=0`.
- Corrupt RX beat 2 data and send `tdest=1` with `chan=0` on beat 5, `len=6` → `err_count=2`.
- Early `tlast` on beat 2 of `len=5` → `done`, `rx_beats=3`, `err_count=1`.
- No RX traffic, `TIMEOUT=16` → `timeout=1` and `done` 16 cycles after the last activity, `err_count=1`, `m_axis_tvalid=0`.
- Assert `resetn=0` mid-SEND, plus a `len=0` start → all outputs 0 immediately, no `done`, `busy` stays 0 for `len=0`.

Source files
------------

// File: rtl/dma_exer_pkg.sv
// Shared types and constants for the DMA stream exerciser: FSM states,
// pattern modes, LFSR polynomial and saturating error-count helper.
package dma_exer_pkg;

    typedef enum logic [1:0] {
        TX_IDLE,
        TX_SEND,
        TX_TXDONE
    } tx_state_t;

    typedef enum logic [1:0] {
        RX_IDLE,
        RX_RECV,
        RX_FIN
    } rx_state_t;

    localparam logic MODE_INC  = 1'b0;
    localparam logic MODE_LFSR = 1'b1;

    // Right-shifting Galois form of x^32+x^22+x^2+x+1
    localparam logic [31:0] LFSR_POLY = 32'h8020_0003;
    localparam logic [15:0] ERR_SAT   = 16'hFFFF;

    function automatic logic [31:0] lfsr_step(input logic [31:0] s);
        return (s >> 1) ^ (s[0] ? LFSR_POLY : 32'h0);
    endfunction

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == ERR_SAT) ? v : v + 16'd1;
    endfunction

endpackage

// File: rtl/dma_exer_pattern.sv
// Beat pattern generator: loads a seed, steps once per accepted beat and
// presents the current pattern word (incrementing or LFSR).
module dma_exer_pattern
    import dma_exer_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_load,
    input  logic              i_mode,
    input  logic [31:0]       i_seed,
    input  logic              i_step,
    output logic [DATA_W-1:0] o_data
);

    logic        r_mode;
    logic [31:0] r_state;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mode  <= MODE_INC;
            r_state <= '0;
        end else if (i_load) begin
            r_mode  <= i_mode;
            // An all-zero LFSR would lock up, so a zero seed starts at 1
            r_state <= (i_mode == MODE_LFSR && i_seed == '0) ? 32'd1 : i_seed;
        end else if (i_step) begin
            r_state <= (r_mode == MODE_LFSR) ? lfsr_step(r_state) : r_state + 32'd1;
        end
    end

    assign o_data = r_state[DATA_W-1:0];

endmodule

// File: rtl/dma_stream_exerciser.sv
// AXI4-Stream traffic generator/checker for DMA loopback: sends a pattern on
// m_axis, checks the returned s_axis stream, with a progress watchdog.
module dma_stream_exerciser
    import dma_exer_pkg::*;
#(
    parameter  int DATA_W  = 32,
    parameter  int NUM_CH  = 2,
    parameter  int LEN_W   = 16,
    parameter  int TIMEOUT = 1024,
    localparam int CH_W    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
    localparam int WD_W    = $clog2(TIMEOUT + 1)
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              start,
    input  logic              mode,
    input  logic [CH_W-1:0]   chan,
    input  logic [LEN_W-1:0]  len,
    input  logic [31:0]       seed,
    output logic [DATA_W-1:0] m_axis_tdata,
    output logic              m_axis_tvalid,
    input  logic              m_axis_tready,
    output logic              m_axis_tlast,
    output logic [CH_W-1:0]   m_axis_tdest,
    input  logic [DATA_W-1:0] s_axis_tdata,
    input  logic              s_axis_tvalid,
    output logic              s_axis_tready,
    input  logic              s_axis_tlast,
    input  logic [CH_W-1:0]   s_axis_tdest,
    output logic              busy,
    output logic              done,
    output logic              timeout,
    output logic [15:0]       err_count,
    output logic [LEN_W-1:0]  rx_beats
);

    tx_state_t r_tx_state, w_tx_next;
    rx_state_t r_rx_state, w_rx_next;

    logic [CH_W-1:0]   r_chan;
    logic [LEN_W-1:0]  r_len;
    logic [LEN_W-1:0]  r_tx_cnt;
    logic              r_tlast;
    logic [LEN_W-1:0]  r_rx_beats;
    logic [15:0]       r_err;
    logic              r_timeout;
    logic [WD_W-1:0]   r_wdog;

    logic [DATA_W-1:0] w_tx_data;
    logic [DATA_W-1:0] w_exp_data;
    logic              w_accept;
    logic              w_tx_hs;
    logic              w_rx_hs;
    logic              w_rx_last;
    logic              w_wd_hit;
    logic              w_rx_end;
    logic              w_beat_err;

    assign w_accept   = start && (len != '0) && (r_tx_state == TX_IDLE) && (r_rx_state == RX_IDLE);
    assign w_tx_hs    = (r_tx_state == TX_SEND) && m_axis_tready;
    assign w_rx_hs    = (r_rx_state == RX_RECV) && s_axis_tvalid;
    assign w_rx_last  = (r_rx_beats == (r_len - LEN_W'(1)));
    assign w_wd_hit   = (r_rx_state == RX_RECV) && !w_rx_hs && (r_wdog == WD_W'(TIMEOUT - 1));
    assign w_rx_end   = w_wd_hit || (w_rx_hs && (w_rx_last || s_axis_tlast));
    assign w_beat_err = (s_axis_tdata != w_exp_data) || (s_axis_tdest != r_chan) ||
                        (s_axis_tlast != w_rx_last);

    dma_exer_pattern #(.DATA_W(DATA_W)) u_tx_pat (
        .clk    (clk),
        .rst_n  (resetn),
        .i_load (w_accept),
        .i_mode (mode),
        .i_seed (seed),
        .i_step (w_tx_hs),
        .o_data (w_tx_data)
    );

    dma_exer_pattern #(.DATA_W(DATA_W)) u_rx_pat (
        .clk    (clk),
        .rst_n  (resetn),
        .i_load (w_accept),
        .i_mode (mode),
        .i_seed (seed),
        .i_step (w_rx_hs),
        .o_data (w_exp_data)
    );

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_tx_state <= TX_IDLE;
            r_rx_state <= RX_IDLE;
        end else begin
            r_tx_state <= w_tx_next;
            r_rx_state <= w_rx_next;
        end
    end

    // Any RX finish (last beat, early tlast, watchdog) also retires the TX side
    always_comb begin
        w_tx_next     = r_tx_state;
        w_rx_next     = r_rx_state;
        m_axis_tvalid = 1'b0;
        s_axis_tready = 1'b0;
        busy          = 1'b0;
        done          = 1'b0;
        unique case (r_tx_state)
            TX_IDLE:   if (w_accept) w_tx_next = TX_SEND;
            TX_SEND: begin
                m_axis_tvalid = 1'b1;
                if (w_rx_end)               w_tx_next = TX_IDLE;
                else if (w_tx_hs && r_tlast) w_tx_next = TX_TXDONE;
            end
            TX_TXDONE: if (w_rx_end) w_tx_next = TX_IDLE;
            default:   w_tx_next = TX_IDLE;
        endcase
        unique case (r_rx_state)
            RX_IDLE: if (w_accept) w_rx_next = RX_RECV;
            RX_RECV: begin
                s_axis_tready = 1'b1;
                busy          = 1'b1;
                if (w_rx_end) w_rx_next = RX_FIN;
            end
            RX_FIN: begin
                done      = 1'b1;
                w_rx_next = RX_IDLE;
            end
            default: w_rx_next = RX_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_chan     <= '0;
            r_len      <= '0;
            r_tx_cnt   <= '0;
            r_tlast    <= 1'b0;
            r_rx_beats <= '0;
            r_err      <= '0;
            r_timeout  <= 1'b0;
            r_wdog     <= '0;
        end else if (w_accept) begin
            r_chan     <= chan;
            r_len      <= len;
            r_tx_cnt   <= '0;
            r_tlast    <= (len == LEN_W'(1));
            r_rx_beats <= '0;
            r_err      <= '0;
            r_timeout  <= 1'b0;
            r_wdog     <= '0;
        end else begin
            if (w_tx_hs) begin
                r_tx_cnt <= r_tx_cnt + LEN_W'(1);
                r_tlast  <= ((r_tx_cnt + LEN_W'(2)) == r_len);
            end
            if (w_rx_hs) begin
                r_rx_beats <= r_rx_beats + LEN_W'(1);
                r_wdog     <= '0;
                if (w_beat_err) r_err <= sat_inc(r_err);
            end else if (w_wd_hit) begin
                r_timeout <= 1'b1;
                r_err     <= sat_inc(r_err);
                r_wdog    <= '0;
            end else if (r_rx_state == RX_RECV) begin
                r_wdog <= r_wdog + WD_W'(1);
            end
        end
    end

    assign m_axis_tdata = w_tx_data;
    assign m_axis_tlast = r_tlast;
    assign m_axis_tdest = r_chan;
    assign timeout      = r_timeout;
    assign err_count    = r_err;
    assign rx_beats     = r_rx_beats;

endmodule

// File: tb/tb_dma_stream_exerciser.sv
// Directed bench for dma_stream_exerciser: loopback, LFSR with backpressure,
// injected RX faults, early tlast, watchdog abort, reset and len=0 handling.
module tb_dma_stream_exerciser;

    logic        clk = 1'b0;
    logic        resetn;
    logic        start;
    logic        mode;
    logic [0:0]  chan;
    logic [15:0] len;
    logic [31:0] seed;
    logic [31:0] m_axis_tdata;
    logic        m_axis_tvalid;
    logic        m_axis_tready;
    logic        m_axis_tlast;
    logic [0:0]  m_axis_tdest;
    logic [31:0] s_axis_tdata;
    logic        s_axis_tvalid;
    logic        s_axis_tready;
    logic        s_axis_tlast;
    logic [0:0]  s_axis_tdest;
    logic        busy;
    logic        done;
    logic        timeout;
    logic [15:0] err_count;
    logic [15:0] rx_beats;

    int          total = 0;
    int          bad   = 0;
    logic [31:0] exp_data [16];

    always #5 clk = ~clk;

    dma_stream_exerciser #(
        .DATA_W  (32),
        .NUM_CH  (2),
        .LEN_W   (16),
        .TIMEOUT (16)
    ) dut (
        .clk           (clk),
        .resetn        (resetn),
        .start         (start),
        .mode          (mode),
        .chan          (chan),
        .len           (len),
        .seed          (seed),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tready (m_axis_tready),
        .m_axis_tlast  (m_axis_tlast),
        .m_axis_tdest  (m_axis_tdest),
        .s_axis_tdata  (s_axis_tdata),
        .s_axis_tvalid (s_axis_tvalid),
        .s_axis_tready (s_axis_tready),
        .s_axis_tlast  (s_axis_tlast),
        .s_axis_tdest  (s_axis_tdest),
        .busy          (busy),
        .done          (done),
        .timeout       (timeout),
        .err_count     (err_count),
        .rx_beats      (rx_beats)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic drive_mready(input int mt_mode);
        case (mt_mode)
            0:       return 1'b1;
            1:       return ($urandom_range(0, 3) != 0);
            default: return 1'b0;
        endcase
    endfunction

    // mt_mode: 0 = m_axis_tready always 1, 1 = random, 2 = always 0
    task automatic xfer(input logic md, input logic [31:0] sd, input int ln, input logic ch,
                        input int mt_mode, input bit bp, input bit rx_on,
                        input int corrupt_i, input int dest_i, input int early_i,
                        input int exp_err, input int exp_rx, input logic exp_to,
                        input int exp_done_cyc, input int exp_tx);
        logic [31:0] q_d[$];
        logic        q_l[$];
        logic        q_t[$];
        int          tx_n = 0, rx_sent = 0, cyc = 0, done_cyc = -1;
        bit          done_seen = 0, stall = 0, s_hs;
        logic [31:0] hold_d = '0;
        logic        hold_l = 1'b0;

        @(posedge clk); #1;
        mode = md; seed = sd; len = 16'(ln); chan = ch; start = 1'b1;
        m_axis_tready = drive_mready(mt_mode);
        @(posedge clk); #1;
        start = 1'b0;
        chk("accept_busy", busy, 1'b1);
        chk("accept_tvalid", m_axis_tvalid, 1'b1);
        chk("accept_tdata", m_axis_tdata, exp_data[0]);

        while (!done_seen && cyc < 200) begin
            @(negedge clk);
            if (done) begin
                done_seen = 1;
                done_cyc  = cyc;
                chk("done_busy", busy, 1'b0);
                chk("done_tvalid", m_axis_tvalid, 1'b0);
                chk("done_tready", s_axis_tready, 1'b0);
            end else begin
                if (m_axis_tvalid) begin
                    if (stall) begin
                        chk("tx_hold_data", m_axis_tdata, hold_d);
                        chk("tx_hold_last", m_axis_tlast, hold_l);
                    end
                    if (m_axis_tready) begin
                        chk("tx_data", m_axis_tdata, exp_data[tx_n]);
                        chk("tx_last", m_axis_tlast, tx_n == ln - 1);
                        chk("tx_dest", m_axis_tdest, ch);
                        q_d.push_back(m_axis_tdata);
                        q_l.push_back(m_axis_tlast);
                        q_t.push_back(m_axis_tdest);
                        tx_n++;
                        stall = 0;
                    end else begin
                        stall  = 1;
                        hold_d = m_axis_tdata;
                        hold_l = m_axis_tlast;
                    end
                end
                s_hs = s_axis_tvalid && s_axis_tready;
                @(posedge clk); #1;
                m_axis_tready = drive_mready(mt_mode);
                if (s_hs) s_axis_tvalid = 1'b0;
                if (!s_axis_tvalid && rx_on && q_d.size() > 0 && (!bp || $urandom_range(0, 3) != 0)) begin
                    s_axis_tdata  = q_d.pop_front() ^ ((rx_sent == corrupt_i) ? 32'h1 : 32'h0);
                    s_axis_tdest  = q_t.pop_front() ^ ((rx_sent == dest_i) ? 1'b1 : 1'b0);
                    s_axis_tlast  = q_l.pop_front() | (rx_sent == early_i);
                    s_axis_tvalid = 1'b1;
                    rx_sent++;
                end
                cyc++;
            end
        end

        chk("done_seen", done_seen, 1'b1);
        if (exp_done_cyc >= 0) chk("done_cycle", done_cyc, exp_done_cyc);
        chk("err_count", err_count, exp_err);
        chk("rx_beats", rx_beats, exp_rx);
        chk("timeout", timeout, exp_to);
        chk("tx_beats", tx_n, exp_tx);
        s_axis_tvalid = 1'b0;
        m_axis_tready = 1'b0;
        @(posedge clk); @(negedge clk);
        chk("done_pulse", done, 1'b0);
        chk("post_rx_beats", rx_beats, exp_rx);
    endtask

    initial begin
        resetn = 1'b0; start = 1'b0; mode = 1'b0; chan = '0; len = '0; seed = '0;
        m_axis_tready = 1'b0;
        s_axis_tvalid = 1'b0; s_axis_tdata = '0; s_axis_tlast = 1'b0; s_axis_tdest = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_busy", busy, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_tvalid", m_axis_tvalid, 1'b0);
        chk("rst_tready", s_axis_tready, 1'b0);
        chk("rst_err", err_count, 16'h0);
        chk("rst_timeout", timeout, 1'b0);
        resetn = 1'b1;

        // Incrementing loopback, seed 0x10, len 4, channel 1
        exp_data[0] = 32'h10; exp_data[1] = 32'h11; exp_data[2] = 32'h12; exp_data[3] = 32'h13;
        xfer(1'b0, 32'h10, 4, 1'b1, 0, 1'b0, 1'b1, -1, -1, -1, 0, 4, 1'b0, 5, 4);

        // LFSR from seed 0 (runs as seed 1) with random backpressure both sides
        exp_data[0] = 32'h0000_0001; exp_data[1] = 32'h8020_0003;
        exp_data[2] = 32'hC030_0002; exp_data[3] = 32'h6018_0001;
        exp_data[4] = 32'hB02C_0003; exp_data[5] = 32'hD836_0002;
        exp_data[6] = 32'h6C1B_0001; exp_data[7] = 32'hB62D_8003;
        xfer(1'b1, 32'h0, 8, 1'b0, 1, 1'b1, 1'b1, -1, -1, -1, 0, 8, 1'b0, -1, 8);

        // Corrupt data on beat 2 and tdest on beat 5
        for (int i = 0; i < 6; i++) exp_data[i] = 32'h100 + 32'(i);
        xfer(1'b0, 32'h100, 6, 1'b0, 0, 1'b0, 1'b1, 2, 5, -1, 2, 6, 1'b0, 7, 6);

        // Early tlast on beat 2 of 5, with 32-bit wrap in the increment pattern
        exp_data[0] = 32'hFFFF_FFFE; exp_data[1] = 32'hFFFF_FFFF;
        exp_data[2] = 32'h0;         exp_data[3] = 32'h1; exp_data[4] = 32'h2;
        xfer(1'b0, 32'hFFFF_FFFE, 5, 1'b0, 0, 1'b0, 1'b1, -1, -1, 2, 1, 3, 1'b0, 4, 4);

        // No RX traffic and a stalled m_axis: watchdog abort after 16 cycles
        exp_data[0] = 32'h55;
        xfer(1'b0, 32'h55, 4, 1'b0, 2, 1'b0, 1'b0, -1, -1, -1, 1, 0, 1'b1, 16, 0);

        // Reset mid-SEND after one erroneous RX beat
        @(posedge clk); #1;
        mode = 1'b0; seed = 32'h200; len = 16'd5; chan = '0; start = 1'b1; m_axis_tready = 1'b0;
        @(posedge clk); #1;
        start = 1'b0;
        s_axis_tvalid = 1'b1; s_axis_tdata = 32'hDEAD; s_axis_tdest = '0; s_axis_tlast = 1'b0;
        @(posedge clk); #1;
        s_axis_tvalid = 1'b0;
        chk("pre_rst_err", err_count, 16'd1);
        chk("pre_rst_rx", rx_beats, 16'd1);
        chk("pre_rst_busy", busy, 1'b1);
        chk("pre_rst_tvalid", m_axis_tvalid, 1'b1);
        #2 resetn = 1'b0;
        #1;
        chk("arst_busy", busy, 1'b0);
        chk("arst_tvalid", m_axis_tvalid, 1'b0);
        chk("arst_tdata", m_axis_tdata, 32'h0);
        chk("arst_tlast", m_axis_tlast, 1'b0);
        chk("arst_tready", s_axis_tready, 1'b0);
        chk("arst_done", done, 1'b0);
        chk("arst_err", err_count, 16'h0);
        chk("arst_rx", rx_beats, 16'h0);
        chk("arst_timeout", timeout, 1'b0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("arst_no_done", done, 1'b0);
        end
        @(posedge clk); #1;
        resetn = 1'b1;

        // len = 0 start is ignored
        @(posedge clk); #1;
        len = 16'd0; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("len0_busy", busy, 1'b0);
            chk("len0_done", done, 1'b0);
            chk("len0_tvalid", m_axis_tvalid, 1'b0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
